rsa_byte_stream_loader: RTL and testbench

//  Byte-stream front/back end for the RSA decryption core.
//  - Assembles modulus N, private exponent D and successive cipher blocks from an 8-bit valid/ready stream.
//  - Launches the core once per block, then serializes the plaintext result back out as bytes.
//  - Sits between the Avalon/RS232 byte bridge and the RSA core; this block owns all operand registers.

---
 rtl/rsa_pkg.sv | 38 +++
 rtl/rsa_byte_shifter.sv | 41 ++++
 rtl/rsa_byte_stream_loader.sv | 196 +++++++++++++++++++
 tb/tb_rsa_byte_stream_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// ---------------------------------------------------------------------------
// rsa_pkg
// Shared constants, loader state encoding and key-size helpers for the RSA
// byte-stream loader and its operand shifters.
// ---------------------------------------------------------------------------
package rsa_pkg;

    localparam int RSA_BIT_MAX      = 1024;
    localparam int RSA_BIT_LOG2_MAX = 10;
    localparam int BYTE_CNT_W       = 8;

    typedef enum logic [2:0] {
        S_GET_N,
        S_GET_D,
        S_GET_A,
        S_START,
        S_WAIT,
        S_SEND
    } loader_state_t;

    // Any key-size code that is not exactly one supported one-hot value falls back to 128 bits.
    function automatic logic [10:0] normalize_bits(input logic [10:0] bits);
        case (bits)
            11'h100, 11'h200, 11'h400: return bits;
            default:                   return 11'h080;
        endcase
    endfunction

    function automatic logic [BYTE_CNT_W-1:0] bytes_per_block(input logic [10:0] bits);
        case (bits)
            11'h100: return BYTE_CNT_W'(32);
            11'h200: return BYTE_CNT_W'(64);
            11'h400: return BYTE_CNT_W'(128);
            default: return BYTE_CNT_W'(16);
        endcase
    endfunction

endpackage

// File: rtl/rsa_byte_shifter.sv
// ---------------------------------------------------------------------------
// rsa_byte_shifter
// One RSA_BIT_MAX-wide operand register. Priority: clear > parallel load >
// byte shift (new byte enters at the LSB end).
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clr          synchronous clear to zero
//   i_load         parallel load of i_load_data
//   i_shift        shift left one byte, inserting i_byte
//   o_q            register contents
// ---------------------------------------------------------------------------
module rsa_byte_shifter
    import rsa_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clr,
    input  logic                   i_load,
    input  logic [RSA_BIT_MAX-1:0] i_load_data,
    input  logic                   i_shift,
    input  logic [7:0]             i_byte,
    output logic [RSA_BIT_MAX-1:0] o_q
);

    logic [RSA_BIT_MAX-1:0] r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift) begin
            r_q <= {r_q[RSA_BIT_MAX-9:0], i_byte};
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/rsa_byte_stream_loader.sv
// ---------------------------------------------------------------------------
// rsa_byte_stream_loader
// Byte-stream front/back end for the RSA decryption core. Collects N, D and
// cipher blocks A MSB-first from an 8-bit valid/ready stream, starts the
// core, and returns the plaintext (top byte dropped) as L-1 bytes.
// Optional build macro: RSA_LOADER_RELOAD_EN adds i_reload, which forces a
// full restart at S_GET_N with all operands cleared.
// Ports:
//   i_clk, i_rst                  clock, asynchronous active-high reset
//   i_reload                      (RSA_LOADER_RELOAD_EN only) restart request
//   i_rsa_bit                     key size one-hot, sampled on first N byte
//   i_in_data/i_in_valid/o_in_ready        input byte stream
//   o_out_data/o_out_valid/i_out_ready     plaintext byte stream
//   o_core_start                  one-cycle core launch
//   o_core_a/d/n, o_core_rsa_bit  operands and latched key size to core
//   i_core_a_pow_d, i_core_finished        core result and done flag
//   o_busy                        high in S_START, S_WAIT and S_SEND
// ---------------------------------------------------------------------------
module rsa_byte_stream_loader
    import rsa_pkg::*;
#(
    parameter int unsigned BYTE_CNT_W = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
`ifdef RSA_LOADER_RELOAD_EN
    input  logic                   i_reload,
`endif
    input  logic [10:0]            i_rsa_bit,
    input  logic [7:0]             i_in_data,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    output logic [7:0]             o_out_data,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic                   o_core_start,
    output logic [RSA_BIT_MAX-1:0] o_core_a,
    output logic [RSA_BIT_MAX-1:0] o_core_d,
    output logic [RSA_BIT_MAX-1:0] o_core_n,
    output logic [10:0]            o_core_rsa_bit,
    input  logic [RSA_BIT_MAX-1:0] i_core_a_pow_d,
    input  logic                   i_core_finished,
    output logic                   o_busy
);

    loader_state_t          r_state;
    logic [BYTE_CNT_W-1:0]  r_cnt;
    logic [10:0]            r_rsa_bit;
    logic                   r_core_start;
    logic                   r_out_valid;

    logic                        w_reload;
    logic [BYTE_CNT_W-1:0]       w_len;
    logic [BYTE_CNT_W-1:0]       w_len_m1;
    logic [BYTE_CNT_W-1:0]       w_len_m2;
    logic [RSA_BIT_LOG2_MAX-1:0] w_top_lsb;
    logic                        w_in_xfer;
    logic                        w_in_last;
    logic                        w_out_xfer;
    logic                        w_out_last;
    logic [RSA_BIT_MAX-1:0]      w_res;

`ifdef RSA_LOADER_RELOAD_EN
    assign w_reload = i_reload;
`else
    assign w_reload = 1'b0;
`endif

    assign w_len    = BYTE_CNT_W'(bytes_per_block(r_rsa_bit));
    assign w_len_m1 = w_len - BYTE_CNT_W'(1);
    assign w_len_m2 = w_len - BYTE_CNT_W'(2);
    // Result shifts left one byte per sent byte, so the next byte always sits at byte L-2.
    assign w_top_lsb = RSA_BIT_LOG2_MAX'({w_len_m2, 3'b000});

    assign o_in_ready = (r_state == S_GET_N) || (r_state == S_GET_D) || (r_state == S_GET_A);
    assign o_busy     = (r_state == S_START) || (r_state == S_WAIT) || (r_state == S_SEND);

    assign w_in_xfer  = i_in_valid && o_in_ready && !w_reload;
    assign w_in_last  = (r_cnt == w_len_m1);
    assign w_out_xfer = (r_state == S_SEND) && r_out_valid && i_out_ready && !w_reload;
    assign w_out_last = (r_cnt == w_len_m2);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_GET_N;
            r_cnt        <= '0;
            r_rsa_bit    <= '0;
            r_core_start <= 1'b0;
            r_out_valid  <= 1'b0;
        end else if (w_reload) begin
            r_state      <= S_GET_N;
            r_cnt        <= '0;
            r_core_start <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_GET_N, S_GET_D, S_GET_A: begin
                    if (w_in_xfer) begin
                        if (r_state == S_GET_N && r_cnt == '0) begin
                            r_rsa_bit <= normalize_bits(i_rsa_bit);
                        end
                        if (w_in_last) begin
                            r_cnt <= '0;
                            unique case (r_state)
                                S_GET_N: r_state <= S_GET_D;
                                S_GET_D: r_state <= S_GET_A;
                                default: begin
                                    r_state      <= S_START;
                                    r_core_start <= 1'b1;
                                end
                            endcase
                        end else begin
                            r_cnt <= r_cnt + BYTE_CNT_W'(1);
                        end
                    end
                end
                S_START: begin
                    r_core_start <= 1'b0;
                    r_state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_core_finished) begin
                        r_state     <= S_SEND;
                        r_out_valid <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (w_out_xfer) begin
                        if (w_out_last) begin
                            r_cnt       <= '0;
                            r_state     <= S_GET_A;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + BYTE_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_GET_N;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    rsa_byte_shifter u_shift_n (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_reload),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift     (w_in_xfer && (r_state == S_GET_N)),
        .i_byte      (i_in_data),
        .o_q         (o_core_n)
    );

    rsa_byte_shifter u_shift_d (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_reload || (w_in_xfer && w_in_last && (r_state == S_GET_N))),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift     (w_in_xfer && (r_state == S_GET_D)),
        .i_byte      (i_in_data),
        .o_q         (o_core_d)
    );

    rsa_byte_shifter u_shift_a (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_reload || (w_in_xfer && w_in_last && (r_state == S_GET_D))
                      || (w_out_xfer && w_out_last)),
        .i_load      (1'b0),
        .i_load_data ('0),
        .i_shift     (w_in_xfer && (r_state == S_GET_A)),
        .i_byte      (i_in_data),
        .o_q         (o_core_a)
    );

    rsa_byte_shifter u_shift_res (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (w_reload),
        .i_load      ((r_state == S_WAIT) && i_core_finished),
        .i_load_data (i_core_a_pow_d),
        .i_shift     (w_out_xfer),
        .i_byte      (8'h00),
        .o_q         (w_res)
    );

    assign o_out_data     = w_res[w_top_lsb +: 8];
    assign o_out_valid    = r_out_valid;
    assign o_core_start   = r_core_start;
    assign o_core_rsa_bit = r_rsa_bit;

endmodule

// File: tb/tb_rsa_byte_stream_loader.sv
module tb_rsa_byte_stream_loader;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_reload;
    logic [10:0]   i_rsa_bit;
    logic [7:0]    i_in_data;
    logic          i_in_valid;
    logic          o_in_ready;
    logic [7:0]    o_out_data;
    logic          o_out_valid;
    logic          i_out_ready;
    logic          o_core_start;
    logic [1023:0] o_core_a;
    logic [1023:0] o_core_d;
    logic [1023:0] o_core_n;
    logic [10:0]   o_core_rsa_bit;
    logic [1023:0] i_core_a_pow_d;
    logic          i_core_finished;
    logic          o_busy;

    int         total = 0;
    int         bad   = 0;
    int         n_out = 0;
    logic [7:0] exp_q[$];

    localparam logic [127:0] N128 = 128'h808182838485868788898A8B8C8D8E8F;
    localparam logic [127:0] D128 = 128'h404142434445464748494A4B4C4D4E4F;
    localparam logic [127:0] A128 = 128'h202122232425262728292A2B2C2D2E2F;
    localparam logic [127:0] A2   = 128'h606162636465666768696A6B6C6D6E6F;
    localparam logic [127:0] R1   = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] R2   = 128'hAA0E0D0C0B0A09080706050403020100;

    always #5 i_clk = ~i_clk;

    rsa_byte_stream_loader u_dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
`ifdef RSA_LOADER_RELOAD_EN
        .i_reload        (i_reload),
`endif
        .i_rsa_bit       (i_rsa_bit),
        .i_in_data       (i_in_data),
        .i_in_valid      (i_in_valid),
        .o_in_ready      (o_in_ready),
        .o_out_data      (o_out_data),
        .o_out_valid     (o_out_valid),
        .i_out_ready     (i_out_ready),
        .o_core_start    (o_core_start),
        .o_core_a        (o_core_a),
        .o_core_d        (o_core_d),
        .o_core_n        (o_core_n),
        .o_core_rsa_bit  (o_core_rsa_bit),
        .i_core_a_pow_d  (i_core_a_pow_d),
        .i_core_finished (i_core_finished),
        .o_busy          (o_busy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a byte is consumed at the posedge after a negedge with valid & ready.
    initial begin
        forever begin
            @(negedge i_clk);
            if (!i_rst && !i_reload && o_out_valid && i_out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got %0h want none", o_out_data);
                end else begin
                    check("out_byte", {120'd0, o_out_data}, {120'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        i_in_valid = 1'b0;
        i_rst      = 1'b1;
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        i_in_data  = b;
        i_in_valid = 1'b1;
        @(negedge i_clk);
        while (!o_in_ready && guard < 1000) begin
            @(negedge i_clk);
            guard++;
        end
        if (!o_in_ready) begin
            total++;
            bad++;
            $display("FAIL in_ready_timeout: got 0 want 1");
        end
        @(posedge i_clk);
        #1 i_in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] base, input logic [7:0] xr, input int len);
        for (int i = 0; i < len; i++) send_byte((base + 8'(i)) ^ xr);
    endtask

    task automatic pulse_finished();
        i_core_finished = 1'b1;
        @(posedge i_clk);
        #1 i_core_finished = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int guard = 0;
        while (exp_q.size() != 0 && guard < budget) begin
            @(posedge i_clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d left want 0", exp_q.size());
        end
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_rst = 1'b1; i_reload = 1'b0; i_rsa_bit = 11'h080; i_in_data = '0; i_in_valid = 1'b0;
        i_out_ready = 1'b1; i_core_a_pow_d = '0; i_core_finished = 1'b0;
        do_reset();
        check("rst_in_ready", o_in_ready, 1);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_start", o_core_start, 0);
        check("rst_busy", o_busy, 0);
        check("rst_rsa_bit", o_core_rsa_bit, 0);

        // Reset in the middle of S_GET_D
        send_seq(8'h80, 8'h00, 16);
        send_seq(8'h40, 8'h00, 5);
        check("getd_nonzero", o_core_d[39:0], 40'h4041424344);
        i_rst = 1'b1;
        #1;
        check("midrst_in_ready", o_in_ready, 1);
        check("midrst_n", |o_core_n, 0);
        check("midrst_d", |o_core_d, 0);
        check("midrst_a", |o_core_a, 0);
        check("midrst_rsa_bit", o_core_rsa_bit, 0);
        do_reset();

        // 128-bit load and launch
        send_seq(8'h80, 8'h00, 16);
        send_seq(8'h40, 8'h00, 16);
        send_seq(8'h20, 8'h00, 16);
        check("start_pulse", o_core_start, 1);
        check("start_busy", o_busy, 1);
        check("start_in_ready", o_in_ready, 0);
        @(posedge i_clk); #1;
        check("start_single", o_core_start, 0);
        check("n128", o_core_n[127:0], N128);
        check("n_lsb", o_core_n[7:0], 8'h8F);
        check("n_upper_zero", |o_core_n[1023:128], 0);
        check("d128", o_core_d[127:0], D128);
        check("a128", o_core_a[127:0], A128);
        check("rsa_bit_128", o_core_rsa_bit, 11'h080);

        // Result with backpressure after the 4th byte
        i_core_a_pow_d = {896'd0, R1};
        for (int k = 1; k <= 15; k++) exp_q.push_back(8'(k * 17));
        n_out = 0;
        repeat (2) @(posedge i_clk);
        #1;
        check("wait_no_valid", o_out_valid, 0);
        pulse_finished();
        check("send_valid", o_out_valid, 1);
        begin
            int guard = 0;
            while (n_out < 4 && guard < 100) begin
                @(posedge i_clk);
                guard++;
            end
        end
        #1 i_out_ready = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        check("bp_data", o_out_data, 8'h55);
        check("bp_valid", o_out_valid, 1);
        i_out_ready = 1'b1;
        wait_drain(200);
        check("blk1_count", n_out, 15);
        check("back_get_a", o_in_ready, 1);
        check("back_busy", o_busy, 0);
        check("n_retained", o_core_n[127:0], N128);
        check("a_cleared", |o_core_a, 0);

        // finished outside S_WAIT is ignored
        pulse_finished();
        @(posedge i_clk); #1;
        check("stray_finish_valid", o_out_valid, 0);
        check("stray_finish_ready", o_in_ready, 1);

        // Second block reuses N and D
        send_seq(8'h60, 8'h00, 16);
        check("blk2_start", o_core_start, 1);
        check("blk2_a", o_core_a[127:0], A2);
        check("blk2_d", o_core_d[127:0], D128);
        i_core_a_pow_d = {896'd0, R2};
        for (int k = 0; k < 15; k++) exp_q.push_back(8'(14 - k));
        n_out = 0;
        @(posedge i_clk); #1;
        pulse_finished();
        wait_drain(200);
        check("blk2_count", n_out, 15);

        // Unsupported size falls back to 128; later i_rsa_bit changes are ignored
        do_reset();
        i_rsa_bit = 11'h300;
        send_seq(8'h80, 8'h00, 16);
        check("fb_rsa_bit", o_core_rsa_bit, 11'h080);
        check("fb_n", o_core_n[127:0], N128);
        check("fb_in_getd", |o_core_d, 0);
        i_rsa_bit = 11'h400;
        send_seq(8'h40, 8'h00, 16);
        send_seq(8'h20, 8'h00, 16);
        check("fb_start", o_core_start, 1);
        check("fb_rsa_bit_held", o_core_rsa_bit, 11'h080);

        // 1024-bit run
        do_reset();
        i_rsa_bit = 11'h400;
        send_seq(8'h00, 8'h00, 128);
        send_seq(8'h00, 8'hFF, 128);
        send_seq(8'h00, 8'h5A, 128);
        check("k1024_start", o_core_start, 1);
        check("k1024_rsa_bit", o_core_rsa_bit, 11'h400);
        check("k1024_n_lo", o_core_n[15:0], 16'h7E7F);
        check("k1024_n_hi", o_core_n[1023:1016], 8'h00);
        check("k1024_d_hi", o_core_d[1023:1016], 8'hFF);
        check("k1024_a_lo", o_core_a[7:0], 8'h25);
        for (int k = 0; k < 128; k++) i_core_a_pow_d[k*8 +: 8] = 8'(k);
        for (int k = 0; k < 127; k++) exp_q.push_back(8'(126 - k));
        n_out = 0;
        @(posedge i_clk); #1;
        pulse_finished();
        wait_drain(500);
        check("k1024_count", n_out, 127);
        check("k1024_back_get_a", o_in_ready, 1);

`ifdef RSA_LOADER_RELOAD_EN
        do_reset();
        i_rsa_bit = 11'h080;
        send_seq(8'h80, 8'h00, 16);
        send_seq(8'h40, 8'h00, 16);
        send_seq(8'h20, 8'h00, 16);
        i_core_a_pow_d = {896'd0, R1};
        for (int k = 1; k <= 15; k++) exp_q.push_back(8'(k * 17));
        n_out = 0;
        @(posedge i_clk); #1;
        pulse_finished();
        begin
            int guard = 0;
            while (n_out < 3 && guard < 100) begin
                @(posedge i_clk);
                guard++;
            end
        end
        #1 i_reload = 1'b1;
        @(posedge i_clk);
        #1 i_reload = 1'b0;
        exp_q.delete();
        check("reload_valid", o_out_valid, 0);
        check("reload_in_ready", o_in_ready, 1);
        check("reload_busy", o_busy, 0);
        check("reload_n", |o_core_n, 0);
        check("reload_d", |o_core_d, 0);
        check("reload_a", |o_core_a, 0);
`endif

        repeat (3) @(posedge i_clk);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
